seq_mult6_ctrl: RTL and testbench



---
 rtl/seq_mult6_ctrl_if.sv | 29 ++
 rtl/seq_mult6_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_mult6_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_mult6_ctrl_if.sv
// ============================================================================
// Module   : seq_mult6_ctrl_if
// Brief    : Start/done request interface of the sequential 6x6 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mult6_ctrl_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

`default_nettype wire

// File: rtl/seq_mult6_ctrl.sv
// ============================================================================
// Module   : seq_mult6_ctrl
// Brief    : 6x6 unsigned shift-add multiplier sharing one ripple-carry adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder6 #(
    parameter int WIDTH = 6
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];
endmodule

module seq_mult6_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_mult6_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_p;
    logic                   r_c;
    logic [CNT_W-1:0]       r_count;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;

    full_adder6 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (r_p),
        .b    (r_a),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_p       <= '0;
            r_c       <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_q     <= bus.b;
                        r_p     <= '0;
                        r_c     <= 1'b0;
                        r_count <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    // The add carry must survive into the shift, where it becomes P[5].
                    if (r_q[0]) begin
                        r_p <= w_sum;
                        r_c <= w_cout;
                    end else begin
                        r_c <= 1'b0;
                    end
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_c, r_p, r_q} <= {1'b0, r_c, r_p, r_q[WIDTH-1:1]};
                    r_count         <= r_count + CNT_W'(1);
                    if (r_count == c_last_iter) begin
                        // Load the post-shift {P,Q} directly rather than waiting a cycle.
                        r_product <= {r_c, r_p, r_q[WIDTH-1:1]};
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_ADD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = r_product;
endmodule

`default_nettype wire

// File: tb/tb_seq_mult6_ctrl.sv
// ============================================================================
// Module   : tb_seq_mult6_ctrl
// Brief    : Directed self-checking bench for the sequential 6x6 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult6_ctrl;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    seq_mult6_ctrl_if #(.WIDTH(6)) bus_if ();

    seq_mult6_ctrl #(
        .WIDTH (6),
        .CNT_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
        end
    endtask

    // Full operation with a one-cycle start; checks exact done timing.
    task automatic run_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                          input logic [11:0] exp);
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.start = 1'b1;
        tick();                                   // E0
        bus_if.start = 1'b0;
        bus_if.a     = 6'h15;
        bus_if.b     = 6'h2B;
        check({tag, "_busy_e0"}, {11'd0, bus_if.busy}, 12'd1);
        repeat (11) tick();                       // E11
        check({tag, "_done_e11"}, {11'd0, bus_if.done}, 12'd0);
        tick();                                   // E12
        check({tag, "_done_e12"}, {11'd0, bus_if.done}, 12'd1);
        check({tag, "_busy_e12"}, {11'd0, bus_if.busy}, 12'd1);
        check({tag, "_product"}, bus_if.product, exp);
        tick();                                   // E13
        check({tag, "_done_e13"}, {11'd0, bus_if.done}, 12'd0);
        check({tag, "_busy_e13"}, {11'd0, bus_if.busy}, 12'd0);
        check({tag, "_product_hold"}, bus_if.product, exp);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.a      = 6'd0;
        bus_if.b      = 6'd0;
        #3;
        check("reset_busy", {11'd0, bus_if.busy}, 12'd0);
        check("reset_done", {11'd0, bus_if.done}, 12'd0);
        check("reset_product", bus_if.product, 12'h000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", {11'd0, bus_if.busy}, 12'd0);

        run_op("m5x7", 6'd5, 6'd7, 12'h023);
        run_op("m63x63", 6'h3F, 6'h3F, 12'hF81);
        run_op("m0x2a", 6'h00, 6'h2A, 12'h000);
        run_op("m2ax0", 6'h2A, 6'h00, 12'h000);
        run_op("m1x63", 6'h01, 6'h3F, 12'h03F);

        // start while busy: in cycle 5 and again in the DONE cycle
        bus_if.a = 6'd3; bus_if.b = 6'd4; bus_if.start = 1'b1;
        tick();                                   // E0
        bus_if.start = 1'b0;
        repeat (4) tick();                        // E4
        bus_if.a = 6'd9; bus_if.b = 6'd9; bus_if.start = 1'b1;
        tick();                                   // E5
        bus_if.start = 1'b0;
        check("busy_start_ign_busy", {11'd0, bus_if.busy}, 12'd1);
        repeat (6) tick();                        // E11
        check("busy_start_nodone_e11", {11'd0, bus_if.done}, 12'd0);
        tick();                                   // E12
        check("busy_start_done", {11'd0, bus_if.done}, 12'd1);
        check("busy_start_product", bus_if.product, 12'h00C);
        bus_if.start = 1'b1;
        tick();                                   // E13: start ignored in DONE
        bus_if.start = 1'b0;
        check("done_start_ign_busy", {11'd0, bus_if.busy}, 12'd0);
        tick();
        check("done_start_still_idle", {11'd0, bus_if.busy}, 12'd0);
        check("done_start_product", bus_if.product, 12'h00C);

        // start held high: one operation every 14 cycles
        bus_if.a = 6'h21; bus_if.b = 6'h02; bus_if.start = 1'b1;
        tick();                                   // E0
        repeat (12) tick();                       // E12
        check("held_done1", {11'd0, bus_if.done}, 12'd1);
        check("held_product1", bus_if.product, 12'h042);
        tick();                                   // E13
        check("held_idle_gap", {11'd0, bus_if.busy}, 12'd0);
        tick();                                   // E14 re-accept
        check("held_reaccept", {11'd0, bus_if.busy}, 12'd1);
        repeat (6) tick();                        // E20
        check("held_product_stable", bus_if.product, 12'h042);
        check("held_nodone_mid", {11'd0, bus_if.done}, 12'd0);
        repeat (6) tick();                        // E26
        check("held_done2", {11'd0, bus_if.done}, 12'd1);
        check("held_product2", bus_if.product, 12'h042);
        bus_if.start = 1'b0;
        tick();

        // asynchronous reset mid-operation
        run_op("pre_reset_5x7", 6'd5, 6'd7, 12'h023);
        bus_if.a = 6'd9; bus_if.b = 6'd9; bus_if.start = 1'b1;
        tick();                                   // E0
        bus_if.start = 1'b0;
        repeat (7) tick();                        // cycle 7
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {11'd0, bus_if.busy}, 12'd0);
        check("async_rst_done", {11'd0, bus_if.done}, 12'd0);
        check("async_rst_product", bus_if.product, 12'h000);
        tick();
        rst_n = 1'b1;
        repeat (14) tick();
        check("post_rst_no_restart", {11'd0, bus_if.busy}, 12'd0);
        check("post_rst_product", bus_if.product, 12'h000);
        run_op("m2x3", 6'd2, 6'd3, 12'h006);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
